// File: rtl/ext_bus_initiator.sv
// ext_bus_initiator: one-at-a-time read/write initiator for the
// external side of the HPS-to-fabric Avalon bridge.
//
// Ports: clk, reset_n (async, active low)
//   cmd_*  : valid/ready command in (write, addr, be, wdata)
//   rsp_*  : valid/ready response out (write echo, rdata, err)
//   bus_*  : registered bridge strobes, held until acknowledge
//   busy   : high whenever the FSM is not IDLE
// Optional: define EXT_BUS_TIMEOUT_EN for a watchdog that ends an
// access with rsp_err=1 after TIMEOUT_CYCLES strobe cycles.
module ext_bus_initiator #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W/8-1:0] cmd_be,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   bus_address,
  output logic [DATA_W/8-1:0] bus_byte_enable,
  output logic                bus_read,
  output logic                bus_write,
  output logic [DATA_W-1:0]   bus_write_data,
  input  logic                bus_acknowledge,
  input  logic [DATA_W-1:0]   bus_read_data,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                rvalid_q, rvalid_d;
  logic                rwrite_q, rwrite_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef EXT_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Last strobe cycle: counter has seen TIMEOUT_CYCLES-1 misses,
  // so strobes stay high for exactly TIMEOUT_CYCLES cycles.
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    rvalid_d = rvalid_q;
    rwrite_d = rwrite_q;
    rdata_d  = rdata_q;
`ifdef EXT_BUS_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          be_d    = cmd_be;
          wdata_d = cmd_wdata;
          rd_d    = ~cmd_write;
          wr_d    = cmd_write;
`ifdef EXT_BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Acknowledge is checked first so it beats a
        // coinciding timeout.
        if (bus_acknowledge) begin
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          rvalid_d = 1'b1;
          rwrite_d = wr_q;
          rdata_d  = wr_q ? '0 : bus_read_data;
`ifdef EXT_BUS_TIMEOUT_EN
          err_d    = 1'b0;
`endif
          state_d  = RESP;
        end
`ifdef EXT_BUS_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          rvalid_d = 1'b1;
          rwrite_d = wr_q;
          rdata_d  = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rwrite_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      rvalid_q <= rvalid_d;
      rwrite_q <= rwrite_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef EXT_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign bus_address     = addr_q;
  assign bus_byte_enable = be_q;
  assign bus_write_data  = wdata_q;
  assign bus_read        = rd_q;
  assign bus_write       = wr_q;
  assign rsp_valid       = rvalid_q;
  assign rsp_write       = rwrite_q;
  assign rsp_rdata       = rdata_q;

endmodule

// File: tb/tb_ext_bus_initiator.sv
// tb_ext_bus_initiator: table-driven bench for ext_bus_initiator
// with a response scoreboard and hand-written corner sequences.
module tb_ext_bus_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] bus_address;
  logic [3:0]  bus_byte_enable;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_write_data;
  logic        bus_acknowledge;
  logic [31:0] bus_read_data;
  logic        busy;

  ext_bus_initiator #(
    .ADDR_W(16),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_be(cmd_be),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .bus_address(bus_address),
    .bus_byte_enable(bus_byte_enable),
    .bus_read(bus_read),
    .bus_write(bus_write),
    .bus_write_data(bus_write_data),
    .bus_acknowledge(bus_acknowledge),
    .bus_read_data(bus_read_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] rdata;
    int          hold;
    logic        stale;
    logic        keepv;
  } vec_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  vec_t vecs[6];
  rsp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_be    = v.be;
    cmd_wdata = v.wdata;
  endtask

  task automatic run_txn(input vec_t v, input vec_t nxt);
    rsp_t e;
    rsp_t got;
    chk("idle_ready", cmd_ready, 1);
    chk("idle_strobe", {bus_read, bus_write}, 0);
    drive_cmd(v);
    @(negedge clk);
    cmd_valid = 1'b0;
    e.wr    = v.wr;
    e.rdata = v.wr ? 32'h0 : v.rdata;
    e.err   = 1'b0;
    exp_q.push_back(e);
    for (int k = 0; k <= v.dly; k++) begin
      chk("strobe_hi", {bus_read, bus_write},
          {~v.wr, v.wr});
      chk("addr_hold", bus_address, v.addr);
      chk("be_hold", bus_byte_enable, v.be);
      chk("wdata_hold", bus_write_data, v.wdata);
      chk("busy_access", {busy, cmd_ready, rsp_valid},
          3'b100);
      bus_acknowledge = (k == v.dly);
      bus_read_data   = (k == v.dly) ? v.rdata : $urandom;
      @(negedge clk);
    end
    bus_acknowledge = 1'b0;
    bus_read_data   = $urandom;
    chk("strobe_lo", {bus_read, bus_write}, 0);
    chk("rsp_valid", rsp_valid, 1);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e   = exp_q.pop_front();
      got = {rsp_write, rsp_rdata, rsp_err};
      chk("rsp_data", got, e);
    end
    rsp_ready = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      bus_acknowledge = v.stale;
      bus_read_data   = $urandom;
      if (v.keepv) drive_cmd(nxt);
      @(negedge clk);
      chk("bp_rsp", {rsp_valid, rsp_write, rsp_rdata,
          rsp_err}, {1'b1, e});
      chk("bp_strobe", {bus_read, bus_write}, 0);
      chk("bp_ready", {cmd_ready, busy}, 2'b01);
    end
    bus_acknowledge = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_rsp", {rsp_valid, busy, cmd_ready}, 3'b001);
    chk("post_strobe", {bus_read, bus_write}, 0);
  endtask

  task automatic stale_idle();
    bus_acknowledge = 1'b1;
    bus_read_data   = $urandom;
    @(negedge clk);
    bus_acknowledge = 1'b0;
    chk("stale_idle", {busy, cmd_ready, rsp_valid,
        bus_read, bus_write}, 5'b01000);
  endtask

  initial begin
    vec_t tv;
    vec_t none;
    vecs[0] = '{1'b1, 16'h0010, 4'hF, 32'hCAFEF00D, 2,
                32'h0, 0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h0024, 4'hF, 32'h0, 0,
                32'h12345678, 0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 16'h0030, 4'h3, 32'h55AA55AA, 1,
                32'hA5A50F0F, 5, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 16'h0040, 4'h0, 32'h0, 0,
                32'h0BADBEEF, 2, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 16'hFFFC, 4'h8, 32'h11223344, 4,
                32'h0, 0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'hFFFF, 4'hC, 32'h0, 3,
                32'hFFFFFFFF, 1, 1'b1, 1'b0};
    none = vecs[0];

    reset_n         = 1'b0;
    cmd_valid       = 1'b0;
    cmd_write       = 1'b0;
    cmd_addr        = '0;
    cmd_be          = '0;
    cmd_wdata       = '0;
    rsp_ready       = 1'b0;
    bus_acknowledge = 1'b0;
    bus_read_data   = '0;
    #23 reset_n = 1'b1;
    @(negedge clk);

    chk("rst_ready", cmd_ready, 1);
    chk("rst_flags", {busy, rsp_valid, rsp_write, rsp_err,
        bus_read, bus_write}, 0);
    chk("rst_data", {rsp_rdata, bus_write_data}, 0);
    chk("rst_addr", {bus_address, bus_byte_enable}, 0);

    stale_idle();

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i], (i < 5) ? vecs[i+1] : none);
    end

    stale_idle();

`ifdef EXT_BUS_TIMEOUT_EN
    tv = '{1'b0, 16'h0050, 4'hF, 32'h0, 0, 32'h0, 0,
           1'b0, 1'b0};
    drive_cmd(tv);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("to_strobe_hi", bus_read, 1);
      bus_read_data = $urandom;
      @(negedge clk);
    end
    chk("to_strobe_lo", {bus_read, bus_write}, 0);
    chk("to_rsp", {rsp_valid, rsp_write, rsp_rdata,
        rsp_err}, {1'b1, 1'b0, 32'h0, 1'b1});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("to_done", {rsp_valid, cmd_ready}, 2'b01);
    tv = '{1'b0, 16'h0054, 4'hF, 32'h0, 7, 32'h600DCAFE,
           0, 1'b0, 1'b0};
    run_txn(tv, none);
`endif

    // Reset in the middle of an access.
    tv = '{1'b0, 16'h0060, 4'hF, 32'h0, 0, 32'h0, 0,
           1'b0, 1'b0};
    drive_cmd(tv);
    @(negedge clk);
    chk("ar_strobe", bus_read, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_drop", {bus_read, bus_write}, 0);
    chk("ar_state", {busy, cmd_ready, rsp_valid}, 3'b010);
    cmd_valid = 1'b0;
    #4 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ar_quiet", {rsp_valid, busy, cmd_ready,
          bus_read, bus_write}, 5'b00100);
    end

    tv = vecs[1];
    run_txn(tv, none);

    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
